servo_duty_sequencer: RTL and testbench



---
 rtl/servo_duty_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_servo_duty_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_duty_sequencer.sv
// servo_duty_sequencer
//   Picks the mode source (manual switches or Raspberry Pi lines), debounces
//   the selected mode, maps it to three servo duty targets and slews each pwm
//   duty toward its target by at most STEP counts every STEP_PERIOD cycles.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   manual_on  1 selects sw, 0 selects rpi (asynchronous)
//   sw         manual mode switches (asynchronous)
//   rpi        Raspberry Pi mode lines (asynchronous)
//   duty0..2   duty counts driven straight into the pwm generators
//   mode       currently accepted mode
//   busy       high while any channel is ramping
//   done       one-cycle pulse when all channels reach their targets
//
// States
//   state  | meaning
//   S_IDLE | duties equal targets, waiting for a new target set
//   S_RAMP | stepping duties toward targets once per STEP_PERIOD
module servo_duty_sequencer #(
    parameter int WIDTH         = 26,
    parameter int STABLE_CYCLES = 1000000,
    parameter int STEP_PERIOD   = 100000,
    parameter int STEP          = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             manual_on,
    input  logic [1:0]       sw,
    input  logic [1:0]       rpi,
    output logic [WIDTH-1:0] duty0,
    output logic [WIDTH-1:0] duty1,
    output logic [WIDTH-1:0] duty2,
    output logic [1:0]       mode,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RAMP = 1'b1;

    localparam int SCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TCNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(STEP_PERIOD - 1);
    localparam logic [WIDTH-1:0]  STEP_W    = WIDTH'(STEP);

    function automatic logic [WIDTH-1:0] table_duty(input logic [1:0] m, input int ch);
        logic [WIDTH-1:0] v;
        case (m)
            2'b00:   v = (ch == 0) ? WIDTH'(100000) : WIDTH'(145000);
            2'b01:   v = WIDTH'(50000);
            2'b10:   v = (ch == 0) ? WIDTH'(100000) : ((ch == 1) ? WIDTH'(50000) : WIDTH'(145000));
            default: v = (ch == 0) ? WIDTH'(75000) : WIDTH'(97500);
        endcase
        return v;
    endfunction

    // Step is clamped to the remaining distance, so d+STEP / d-STEP is only
    // taken when it stays strictly between d and t: no overshoot, no wrap.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] d,
                                                     input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] r;
        if (d < t)
            r = ((t - d) > STEP_W) ? d + STEP_W : t;
        else if (d > t)
            r = ((d - t) > STEP_W) ? d - STEP_W : t;
        else
            r = d;
        return r;
    endfunction

    // {manual_on, sw, rpi}
    logic [4:0]        sync1_q, sync1_d;
    logic [4:0]        sync2_q, sync2_d;
    logic [1:0]        cand_q, cand_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  tgt_q [3];
    logic [WIDTH-1:0]  tgt_d [3];
    logic [WIDTH-1:0]  duty_q [3];
    logic [WIDTH-1:0]  duty_d [3];
    logic [WIDTH-1:0]  duty_nxt [3];
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [0:0]        state_q, state_d;
    logic              done_q, done_d;

    logic [1:0] sel;
    logic       step_now;
    logic       off_target;
    logic       nxt_on_target;

    always_comb begin
        sync1_d = {manual_on, sw, rpi};
        sync2_d = sync1_q;
        sel     = sync2_q[4] ? sync2_q[3:2] : sync2_q[1:0];

        cand_d = cand_q;
        scnt_d = scnt_q;
        mode_d = mode_q;
        if (sel != cand_q) begin
            cand_d = sel;
            scnt_d = '0;
        end else if (scnt_q == SCNT_LAST) begin
            // counter saturates; re-accepting the same mode is harmless
            mode_d = cand_q;
        end else begin
            scnt_d = scnt_q + SCNT_W'(1);
        end

        for (int i = 0; i < 3; i++) begin
            tgt_d[i] = table_duty(mode_q, i);
        end

        step_now      = (tcnt_q == TCNT_LAST);
        off_target    = 1'b0;
        nxt_on_target = 1'b1;
        for (int i = 0; i < 3; i++) begin
            duty_nxt[i] = step_now ? step_toward(duty_q[i], tgt_q[i]) : duty_q[i];
            if (duty_q[i] != tgt_q[i])   off_target    = 1'b1;
            if (duty_nxt[i] != tgt_q[i]) nxt_on_target = 1'b0;
        end

        state_d = state_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            duty_d[i] = duty_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (off_target) begin
                    tcnt_d  = '0;
                    state_d = S_RAMP;
                end
            end
            default: begin
                // tcnt keeps running across a retarget so the step cadence holds
                tcnt_d = step_now ? '0 : tcnt_q + TCNT_W'(1);
                for (int i = 0; i < 3; i++) begin
                    duty_d[i] = duty_nxt[i];
                end
                if (nxt_on_target) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            scnt_q  <= '0;
            mode_q  <= 2'b00;
            tcnt_q  <= '0;
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tgt_q[i]  <= table_duty(2'b00, i);
                duty_q[i] <= table_duty(2'b00, i);
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            scnt_q  <= scnt_d;
            mode_q  <= mode_d;
            tcnt_q  <= tcnt_d;
            state_q <= state_d;
            done_q  <= done_d;
            for (int i = 0; i < 3; i++) begin
                tgt_q[i]  <= tgt_d[i];
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign duty0 = duty_q[0];
    assign duty1 = duty_q[1];
    assign duty2 = duty_q[2];
    assign mode  = mode_q;
    assign busy  = (state_q == S_RAMP);
    assign done  = done_q;

endmodule

// File: tb/tb_servo_duty_sequencer.sv
// Bench for servo_duty_sequencer: two instances (STEP=500 and STEP=30000)
// share the inputs; each is compared every cycle with a behavioural model,
// plus directed checks with hand-derived constants.
module tb_servo_duty_sequencer;

    localparam int W = 26;
    localparam int S = 4;
    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         manual_on = 1'b0;
    logic [1:0]   sw = 2'b00;
    logic [1:0]   rpi = 2'b00;
    logic [W-1:0] a_d0, a_d1, a_d2, b_d0, b_d1, b_d2;
    logic [1:0]   a_mode, b_mode;
    logic         a_busy, a_done, b_busy, b_done;

    always #5 clk = ~clk;

    servo_duty_sequencer #(.WIDTH(W), .STABLE_CYCLES(S), .STEP_PERIOD(P), .STEP(500)) dut_a (
        .clk(clk), .rst(rst), .manual_on(manual_on), .sw(sw), .rpi(rpi),
        .duty0(a_d0), .duty1(a_d1), .duty2(a_d2), .mode(a_mode), .busy(a_busy), .done(a_done));

    servo_duty_sequencer #(.WIDTH(W), .STABLE_CYCLES(S), .STEP_PERIOD(P), .STEP(30000)) dut_b (
        .clk(clk), .rst(rst), .manual_on(manual_on), .sw(sw), .rpi(rpi),
        .duty0(b_d0), .duty1(b_d1), .duty2(b_d2), .mode(b_mode), .busy(b_busy), .done(b_done));

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // reference model state
    int         m_step [2] = '{500, 30000};
    int         m_d [2][3];
    int         m_tgt [3];
    logic [1:0] m_mode;
    bit         m_ramp [2];
    bit         m_done [2];
    int         m_start [2];
    logic [1:0] hist [$];

    // observed done pulses per instance since last reset
    int a_dcnt, a_dedge, b_dcnt, b_dedge;

    localparam logic [127:0] RST_EXP = {46'd0, 26'd100000, 26'd145000, 26'd145000, 2'b00, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic int tbl(input logic [1:0] m, input int ch);
        case (m)
            2'b00:   return (ch == 0) ? 100000 : 145000;
            2'b01:   return 50000;
            2'b10:   return (ch == 0) ? 100000 : ((ch == 1) ? 50000 : 145000);
            default: return (ch == 0) ? 75000 : 97500;
        endcase
    endfunction

    function automatic int stepf(input int d, input int t, input int s);
        if (d < t) return ((t - d) > s) ? d + s : t;
        if (d > t) return ((d - t) > s) ? d - s : t;
        return d;
    endfunction

    function automatic logic [127:0] pack_a();
        return {46'd0, a_d0, a_d1, a_d2, a_mode, a_busy, a_done};
    endfunction

    function automatic logic [127:0] pack_b();
        return {46'd0, b_d0, b_d1, b_d2, b_mode, b_busy, b_done};
    endfunction

    function automatic logic [127:0] pack_m(input int k);
        return {46'd0, 26'(m_d[k][0]), 26'(m_d[k][1]), 26'(m_d[k][2]), m_mode, 1'(m_ramp[k]), 1'(m_done[k])};
    endfunction

    task automatic model_reset();
        m_mode = 2'b00;
        for (int ch = 0; ch < 3; ch++) begin
            m_tgt[ch] = tbl(2'b00, ch);
            for (int k = 0; k < 2; k++) m_d[k][ch] = tbl(2'b00, ch);
        end
        for (int k = 0; k < 2; k++) begin
            m_ramp[k]  = 1'b0;
            m_done[k]  = 1'b0;
            m_start[k] = 0;
        end
        hist.delete();
        // synchronizers come out of reset holding zero
        repeat (S + 3) hist.push_back(2'b00);
        edge_n  = 0;
        a_dcnt  = 0;
        a_dedge = -1;
        b_dcnt  = 0;
        b_dedge = -1;
    endtask

    // One clock edge of the model. A mode is accepted once the synchronised
    // selection (two edges late) has been identical for S+1 consecutive edges.
    // Steps land every P edges after the ramp began; a retarget keeps cadence.
    task automatic model_edge();
        logic [1:0] v;
        logic [1:0] new_mode;
        bit         eq;
        bit         diff;
        int         n;
        int         new_tgt [3];
        hist.push_back(manual_on ? sw : rpi);
        if (hist.size() > S + 4) void'(hist.pop_front());
        n  = hist.size();
        v  = hist[n-3];
        eq = 1'b1;
        for (int j = 0; j <= S; j++) if (hist[n-3-j] != v) eq = 1'b0;
        new_mode = eq ? v : m_mode;
        for (int ch = 0; ch < 3; ch++) new_tgt[ch] = tbl(m_mode, ch);
        for (int k = 0; k < 2; k++) begin
            if (!m_ramp[k]) begin
                m_done[k] = 1'b0;
                diff = 1'b0;
                for (int ch = 0; ch < 3; ch++) if (m_d[k][ch] != m_tgt[ch]) diff = 1'b1;
                if (diff) begin
                    m_ramp[k]  = 1'b1;
                    m_start[k] = edge_n;
                end
            end else begin
                if ((edge_n - m_start[k]) % P == 0)
                    for (int ch = 0; ch < 3; ch++) m_d[k][ch] = stepf(m_d[k][ch], m_tgt[ch], m_step[k]);
                diff = 1'b0;
                for (int ch = 0; ch < 3; ch++) if (m_d[k][ch] != m_tgt[ch]) diff = 1'b1;
                m_done[k] = !diff;
                if (!diff) m_ramp[k] = 1'b0;
            end
        end
        for (int ch = 0; ch < 3; ch++) m_tgt[ch] = new_tgt[ch];
        m_mode = new_mode;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        model_edge();
        check("cycle_step500", pack_a(), pack_m(0));
        check("cycle_step30k", pack_b(), pack_m(1));
        if (a_done) begin a_dcnt++; a_dedge = edge_n; end
        if (b_done) begin b_dcnt++; b_dedge = edge_n; end
    endtask

    // Called 1 time unit after a rising edge: asserts rst mid-cycle and checks
    // that outputs fall back without waiting for a clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("reset_a", pack_a(), RST_EXP);
        check("reset_b", pack_b(), RST_EXP);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // glitch shorter than the debounce window is ignored
        rpi = 2'b10;
        repeat (3) tick();
        rpi = 2'b00;
        repeat (15) tick();
        check("glitch", {77'd0, a_mode, a_busy, a_d0, a_d1, a_d2},
              {77'd0, 2'b00, 1'b0, 26'd100000, 26'd145000, 26'd145000});

        // 00 -> 01 ramp via rpi
        do_reset();
        rpi = 2'b01;
        repeat (6) tick();
        check("mode_edge6", 128'(a_mode), 128'(2'b00));
        tick();
        check("mode_edge7", 128'(a_mode), 128'(2'b01));
        tick();
        check("busy_edge8", 128'(a_busy), 128'(1'b0));
        tick();
        check("busy_edge9", 128'(a_busy), 128'(1'b1));
        repeat (7) tick();
        check("pre_step1", {50'd0, a_d0, a_d1, a_d2}, {50'd0, 26'd100000, 26'd145000, 26'd145000});
        tick();
        check("step1_a", {50'd0, a_d0, a_d1, a_d2}, {50'd0, 26'd99500, 26'd144500, 26'd144500});
        check("step1_b", {50'd0, b_d0, b_d1, b_d2}, {50'd0, 26'd70000, 26'd115000, 26'd115000});
        while (edge_n < 809) tick();
        check("step100_a", {50'd0, a_d0, a_d1, a_d2}, {50'd0, 26'd50000, 26'd95000, 26'd95000});
        while (edge_n < 1535) tick();
        check("done_edge_a", 128'(a_dedge), 128'(1529));
        check("done_cnt_a", 128'(a_dcnt), 128'(1));
        check("done_edge_b", 128'(b_dedge), 128'(41));
        check("final_a", {49'd0, a_busy, a_d0, a_d1, a_d2}, {49'd0, 1'b0, 26'd50000, 26'd50000, 26'd50000});

        // clamped steps on the STEP=30000 instance, 00 -> 11
        do_reset();
        rpi = 2'b11;
        while (edge_n < 17) tick();
        check("clamp_step1", {50'd0, b_d0, b_d1, b_d2}, {50'd0, 26'd75000, 26'd115000, 26'd115000});
        while (edge_n < 25) tick();
        check("clamp_step2", {48'd0, b_busy, b_done, b_d0, b_d1, b_d2},
              {48'd0, 1'b0, 1'b1, 26'd75000, 26'd97500, 26'd97500});
        while (edge_n < 60) tick();

        // retarget mid-ramp (also resets while dut_a is still ramping)
        do_reset();
        rpi = 2'b01;
        while (edge_n < 89) tick();
        check("retarget_at", {50'd0, a_d0, a_d1, a_d2}, {50'd0, 26'd95000, 26'd140000, 26'd140000});
        rpi = 2'b00;
        while (edge_n < 300) tick();
        check("retarget_done_edge", 128'(a_dedge), 128'(185));
        check("retarget_done_cnt", 128'(a_dcnt), 128'(1));
        check("retarget_final", {49'd0, a_busy, a_d0, a_d1, a_d2},
              {49'd0, 1'b0, 26'd100000, 26'd145000, 26'd145000});

        // source select
        do_reset();
        manual_on = 1'b1;
        sw = 2'b10;
        rpi = 2'b01;
        while (edge_n < 7) tick();
        check("src_manual_mode", 128'(a_mode), 128'(2'b10));
        while (edge_n < 50) tick();
        check("src_manual_duty", {50'd0, b_d0, b_d1, b_d2}, {50'd0, 26'd100000, 26'd50000, 26'd145000});
        manual_on = 1'b0;
        repeat (6) tick();
        check("src_rpi_early", 128'(a_mode), 128'(2'b10));
        tick();
        check("src_rpi_mode", 128'(a_mode), 128'(2'b01));

        // randomized inputs against the model
        repeat (40) begin
            manual_on = 1'($urandom_range(0, 1));
            sw        = 2'($urandom_range(0, 3));
            rpi       = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 80)) tick();
        end

        do_reset();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
